// File: rtl/dec_entry_pkg.sv
// Shared types and constants for the decimal keypad-entry block.
package dec_entry_pkg;
    typedef enum logic {ST_ENTRY, ST_CONV} state_t;

    localparam int         MAX_DIGITS = 3;
    localparam logic [1:0] MAX_CNT    = 2'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [9:0] VALUE_MAX  = 10'd255;
    localparam int         ERR_BIT    = 8;
    localparam int         BUSY_BIT   = 9;
    localparam int         KEY_PUSH   = 0;
    localparam int         KEY_BS     = 1;
    localparam int         KEY_COMMIT = 2;

    // acc*10 + d without a multiplier
    function automatic logic [9:0] mul10_add(input logic [9:0] acc, input logic [3:0] d);
        return (acc << 3) + (acc << 1) + {6'd0, d};
    endfunction
endpackage

// File: rtl/dec_entry_if.sv
// Board-side switches, keys, LEDs and hex displays of the entry block.
interface dec_entry_if;
    logic [9:0] sw_i;
    logic [2:0] key_i;
    logic [9:0] ledr_o;
    logic [6:0] hex0_o;
    logic [6:0] hex1_o;
    logic [6:0] hex2_o;

    modport master (output sw_i, key_i, input ledr_o, hex0_o, hex1_o, hex2_o);
    modport slave  (input sw_i, key_i, output ledr_o, hex0_o, hex1_o, hex2_o);
endinterface

// File: rtl/dec_entry_debounce.sv
// Per-key conditioning: 2-FF synchroniser, stable counter, one-cycle press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    r_sync;
    logic          r_level;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= 2'b11;
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_press <= 1'b0;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // old level high means this is a press, not a release
                r_level <= r_sync[1];
                r_cnt   <= '0;
                r_press <= r_level;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;
endmodule

// File: rtl/dec_hex.sv
// BCD/hex to active-low 7-segment decoder, segments ordered gfedcba.
module dec_hex (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);
    always_comb begin
        o_seg = 7'b1111111;
        case (i_bcd)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            default: o_seg = 7'b0001110;
        endcase
    end
endmodule

// File: rtl/dec_entry.sv
// Collects up to three BCD digits from the keypad and converts them to binary on commit.
module dec_entry
    import dec_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input logic        clk100_i,
    input logic        rst_i,
    dec_entry_if.slave bus
);
    logic [2:0]      w_press;
    logic [3:0]      w_digit;
    logic [9:0]      w_acc_next;
    logic [2:0][6:0] w_seg;

    state_t          r_state;
    logic [2:0][3:0] r_dig;
    logic [1:0]      r_cnt;
    logic [1:0]      r_idx;
    logic [9:0]      r_acc;
    logic [7:0]      r_value;
    logic            r_err;
    logic            r_busy;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key[2:0] (
        .i_clk   (clk100_i),
        .i_rst   (rst_i),
        .i_key_n (bus.key_i),
        .o_press (w_press)
    );

    // oldest digit first so the accumulator builds most-significant first
    always_comb begin
        w_digit = r_dig[0];
        case (r_idx)
            2'd0:    w_digit = r_dig[2];
            2'd1:    w_digit = r_dig[1];
            default: w_digit = r_dig[0];
        endcase
    end

    assign w_acc_next = mul10_add(r_acc, w_digit);

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_ENTRY;
            r_dig   <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_value <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_ENTRY: begin
                    if (w_press[KEY_COMMIT]) begin
                        if (r_cnt != 2'd0) begin
                            r_state <= ST_CONV;
                            r_idx   <= '0;
                            r_acc   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end else if (w_press[KEY_BS]) begin
                        if (r_cnt != 2'd0) begin
                            r_dig <= {4'd0, r_dig[2], r_dig[1]};
                            r_cnt <= r_cnt - 1'b1;
                            r_err <= 1'b0;
                        end
                    end else if (w_press[KEY_PUSH]) begin
                        if (bus.sw_i[3:0] > BCD_MAX) begin
                            r_err <= 1'b1;
                        end else if (r_cnt != MAX_CNT) begin
                            r_dig <= {r_dig[1], r_dig[0], bus.sw_i[3:0]};
                            r_cnt <= r_cnt + 1'b1;
                            r_err <= 1'b0;
                        end
                    end
                end
                ST_CONV: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == 2'(MAX_DIGITS - 1)) begin
                        if (w_acc_next <= VALUE_MAX) begin
                            r_value <= w_acc_next[7:0];
                            r_err   <= 1'b0;
                        end else begin
                            r_err   <= 1'b1;
                        end
                        r_dig   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_ENTRY;
                    end
                end
                default: r_state <= ST_ENTRY;
            endcase
        end
    end

    dec_hex u_hex[2:0] (
        .i_bcd (r_dig),
        .o_seg (w_seg)
    );

    assign bus.ledr_o = {r_busy, r_err, r_value};
    assign bus.hex0_o = w_seg[0];
    assign bus.hex1_o = w_seg[1];
    assign bus.hex2_o = w_seg[2];
endmodule

// File: tb/tb_dec_entry.sv
// Self-checking bench for dec_entry with a digit-list reference model.
module tb_dec_entry;
    localparam int DEB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dec_entry_if bus ();
    dec_entry #(.DEBOUNCE_CYCLES(DEB)) dut (.clk100_i(clk), .rst_i(rst), .bus(bus));

    // active-low gfedcba segment codes of the decimal digits
    localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt;

    // model: entered digits, oldest first
    int m_digs[$];
    int m_val;
    bit m_err;

    function automatic int mdig(input int pos); // pos 0 = latest
        if (pos < m_digs.size()) return m_digs[m_digs.size() - 1 - pos];
        return 0;
    endfunction

    function automatic logic [30:0] exp_vec();
        return {1'b0, m_err, 8'(m_val), SEG[mdig(2)], SEG[mdig(1)], SEG[mdig(0)]};
    endfunction

    function automatic logic [30:0] obs_vec();
        return {bus.ledr_o, bus.hex2_o, bus.hex1_o, bus.hex0_o};
    endfunction

    task automatic m_reset();
        m_digs.delete(); m_val = 0; m_err = 0;
    endtask

    task automatic m_push(input int d);
        if (d > 9) m_err = 1;
        else if (m_digs.size() < 3) begin m_digs.push_back(d); m_err = 0; end
    endtask

    task automatic m_bs();
        if (m_digs.size() > 0) begin void'(m_digs.pop_back()); m_err = 0; end
    endtask

    task automatic m_commit();
        int v;
        if (m_digs.size() == 0) return;
        v = 0;
        foreach (m_digs[i]) v = v * 10 + m_digs[i];
        if (v <= 255) begin m_val = v; m_err = 0; end
        else m_err = 1;
        m_digs.delete();
    endtask

    // mask bit set = key held low; counts busy cycles while settling
    task automatic press_keys(input logic [2:0] mask, input int hold);
        busy_cnt = 0;
        bus.key_i = ~mask;
        repeat (hold) begin @(negedge clk); if (bus.ledr_o[9]) busy_cnt++; end
        bus.key_i = 3'b111;
        repeat (16) begin @(negedge clk); if (bus.ledr_o[9]) busy_cnt++; end
    endtask

    task automatic push(input int d);
        bus.sw_i = {6'($urandom), 4'(d)};
        press_keys(3'b001, 8);
        m_push(d);
    endtask

    task automatic bs();
        press_keys(3'b010, 8); m_bs();
    endtask

    task automatic commit();
        press_keys(3'b100, 8); m_commit();
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.key_i = 3'b111; bus.sw_i = '0;
        repeat (3) @(negedge clk);
        m_reset();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_fail++;
            $display("FAIL reset: got %h expected %h", obs_vec(), exp_vec()); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic();
        push(1); push(2);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_fail++;
            $display("FAIL basic_entry: got %h expected %h", obs_vec(), exp_vec()); end
        push(3); commit();
        n_checks++;
        if (obs_vec() !== exp_vec() || m_val != 123) begin n_fail++;
            $display("FAIL basic_123: got %h expected %h", obs_vec(), exp_vec()); end
        n_checks++;
        if (busy_cnt !== 3) begin n_fail++;
            $display("FAIL busy_len: got %0d expected 3", busy_cnt); end
    endtask

    task automatic test_overflow();
        push(2); push(5); push(6); commit();
        n_checks++;
        if (obs_vec() !== {2'b01, 8'd123, SEG[0], SEG[0], SEG[0]}) begin n_fail++;
            $display("FAIL overflow_256: got %h", obs_vec()); end
        push(2); push(5); push(5); commit();
        n_checks++;
        if (obs_vec() !== {2'b00, 8'd255, SEG[0], SEG[0], SEG[0]}) begin n_fail++;
            $display("FAIL max_255: got %h", obs_vec()); end
    endtask

    task automatic test_invalid_digit();
        push(10);
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.ledr_o[8] !== 1'b1) begin n_fail++;
            $display("FAIL bad_digit: got %h expected %h", obs_vec(), exp_vec()); end
        push(4);
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.hex0_o !== SEG[4]) begin n_fail++;
            $display("FAIL digit_after_bad: got %h expected %h", obs_vec(), exp_vec()); end
        push(1); push(2); push(3);
        n_checks++;
        if ({bus.hex2_o, bus.hex1_o, bus.hex0_o} !== {SEG[4], SEG[1], SEG[2]}
            || obs_vec() !== exp_vec()) begin n_fail++;
            $display("FAIL full_ignore: got %h expected %h", obs_vec(), exp_vec()); end
        commit();
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.ledr_o[8] !== 1'b1) begin n_fail++;
            $display("FAIL overflow_412: got %h expected %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_backspace();
        push(9); push(8); bs(); commit();
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.ledr_o[7:0] !== 8'd9) begin n_fail++;
            $display("FAIL backspace_9: got %h expected %h", obs_vec(), exp_vec()); end
        bs();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_fail++;
            $display("FAIL backspace_empty: got %h expected %h", obs_vec(), exp_vec()); end
        commit();
        n_checks++;
        if (obs_vec() !== exp_vec() || busy_cnt !== 0) begin n_fail++;
            $display("FAIL commit_empty: got %h busy %0d expected %h", obs_vec(), busy_cnt, exp_vec()); end
    endtask

    task automatic test_debounce();
        bus.sw_i = 10'd7;
        press_keys(3'b001, DEB - 1);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_fail++;
            $display("FAIL glitch: got %h expected %h", obs_vec(), exp_vec()); end
        bus.sw_i = 10'd7;
        press_keys(3'b001, 50); m_push(7);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_fail++;
            $display("FAIL held_key: got %h expected %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_simultaneous();
        bus.sw_i = 10'd5;
        press_keys(3'b101, 8); m_commit();
        n_checks++;
        if (obs_vec() !== exp_vec() || bus.ledr_o[7:0] !== 8'd7) begin n_fail++;
            $display("FAIL commit_and_push: got %h expected %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_conv_drop();
        push(3);
        bus.sw_i = 10'd6;
        bus.key_i = 3'b011;
        repeat (2) @(negedge clk);
        bus.key_i = 3'b010;
        repeat (10) @(negedge clk);
        bus.key_i = 3'b111;
        repeat (16) @(negedge clk);
        m_commit();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_fail++;
            $display("FAIL push_in_conv: got %h expected %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_rst_conv();
        bit seen;
        push(2);
        seen = 0;
        bus.key_i = 3'b011;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.ledr_o[9]) seen = 1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL rst_conv_busy: busy never rose within 40 cycles"); end
        @(posedge clk); #1 rst = 1'b1;
        #1 m_reset();
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_fail++;
            $display("FAIL rst_mid_conv: got %h expected %h", obs_vec(), exp_vec()); end
        bus.key_i = 3'b111;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (16) @(negedge clk);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin n_fail++;
            $display("FAIL after_rst: got %h expected %h", obs_vec(), exp_vec()); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op < 6) push((op == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9));
            else if (op < 8) bs();
            else commit();
            n_checks++;
            if (obs_vec() !== exp_vec()) begin n_fail++;
                $display("FAIL random_%0d op %0d: got %h expected %h", i, op, obs_vec(), exp_vec()); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_invalid_digit();
        test_backspace();
        test_debounce();
        test_simultaneous();
        test_conv_drop();
        test_rst_conv();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
